// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_ctrl
// Description : Command-driven controller for the four user LEDs. Each channel
//               can be set OFF, ON, to BLINK continuously, or to FLASH a
//               burst of N pulses. All timing comes from a shared timebase
//               tick derived from clk.
// Ports       : clk        - system clock
//               rst        - synchronous reset, active-high
//               cmd_valid  - command present
//               cmd_ready  - command accepted this cycle (1 after reset)
//               cmd_ch     - target channel 0..3
//               cmd_mode   - 00 OFF, 01 ON, 10 BLINK, 11 FLASH
//               cmd_period - half-period in ticks (0 treated as 1)
//               cmd_count  - FLASH pulse count (0 = no pulses)
//               led_out    - LED drive, 1 = lit
//               busy       - channel in BLINK or FLASH activity
//               done       - one-cycle pulse when a FLASH burst completes
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int NCH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_ch,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_period,
  input  logic [3:0] cmd_count,
  output logic [3:0] led_out,
  output logic [3:0] busy,
  output logic [3:0] done
);

  localparam int                 c_DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE = c_DIV_W'(1);

  localparam logic [1:0] c_MODE_OFF   = 2'b00;
  localparam logic [1:0] c_MODE_ON    = 2'b01;
  localparam logic [1:0] c_MODE_BLINK = 2'b10;
  localparam logic [1:0] c_MODE_FLASH = 2'b11;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_ON       = 3'd1,
    ST_BLINK_HI = 3'd2,
    ST_BLINK_LO = 3'd3,
    ST_FLASH_HI = 3'd4,
    ST_FLASH_LO = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Shared timebase and handshake
  // --------------------------------------------------------------------------
  logic [c_DIV_W-1:0] r_div;
  logic               r_ready;
  logic               w_tick;
  logic [7:0]         w_cmd_period;

  assign w_tick       = (r_div == c_DIV_MAX);
  assign w_cmd_period = (cmd_period == 8'd0) ? 8'd1 : cmd_period;
  assign cmd_ready    = r_ready;

  // Free-running; commands never touch the divider, so the first phase after
  // a load can be up to one tick short.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_div   <= w_tick ? '0 : (r_div + c_DIV_ONE);
      r_ready <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel pattern engines
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam logic [1:0] c_CH = 2'(gi);

    state_t     r_state;
    logic [7:0] r_phase;
    logic [3:0] r_rem;
    logic [7:0] r_period;
    logic       r_led;
    logic       r_busy;
    logic       r_done;

    state_t     w_nxt_state;
    logic [7:0] w_nxt_phase;
    logic [3:0] w_nxt_rem;
    logic [7:0] w_nxt_period;
    logic       w_nxt_done;
    logic       w_load;
    logic       w_active;

    assign w_load   = cmd_valid & r_ready & (cmd_ch == c_CH);
    assign w_active = (r_state == ST_BLINK_HI) || (r_state == ST_BLINK_LO) ||
                      (r_state == ST_FLASH_HI) || (r_state == ST_FLASH_LO);

    always_comb begin
      w_nxt_state  = r_state;
      w_nxt_phase  = r_phase;
      w_nxt_rem    = r_rem;
      w_nxt_period = r_period;
      w_nxt_done   = 1'b0;
      // A load takes priority over a coincident tick; that tick is dropped
      // so the new pattern always starts from phase count 0.
      if (w_load) begin
        w_nxt_phase  = 8'd0;
        w_nxt_period = w_cmd_period;
        w_nxt_rem    = 4'd0;
        case (cmd_mode)
          c_MODE_OFF:   w_nxt_state = ST_OFF;
          c_MODE_ON:    w_nxt_state = ST_ON;
          c_MODE_BLINK: w_nxt_state = ST_BLINK_HI;
          c_MODE_FLASH: begin
            if (cmd_count == 4'd0) begin
              w_nxt_state = ST_OFF;
              w_nxt_done  = 1'b1;
            end else begin
              w_nxt_state = ST_FLASH_HI;
              w_nxt_rem   = cmd_count;
            end
          end
          default:      w_nxt_state = ST_OFF;
        endcase
      end else if (w_tick && w_active) begin
        if (r_phase == (r_period - 8'd1)) begin
          w_nxt_phase = 8'd0;
          case (r_state)
            ST_BLINK_HI: w_nxt_state = ST_BLINK_LO;
            ST_BLINK_LO: w_nxt_state = ST_BLINK_HI;
            ST_FLASH_HI: w_nxt_state = ST_FLASH_LO;
            ST_FLASH_LO: begin
              // r_rem is at least 1 whenever a FLASH burst is running
              w_nxt_rem = r_rem - 4'd1;
              if (r_rem == 4'd1) begin
                w_nxt_state = ST_OFF;
                w_nxt_done  = 1'b1;
              end else begin
                w_nxt_state = ST_FLASH_HI;
              end
            end
            default:     w_nxt_state = r_state;
          endcase
        end else begin
          w_nxt_phase = r_phase + 8'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state  <= ST_OFF;
        r_phase  <= 8'd0;
        r_rem    <= 4'd0;
        r_period <= 8'd1;
        r_led    <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        r_state  <= w_nxt_state;
        r_phase  <= w_nxt_phase;
        r_rem    <= w_nxt_rem;
        r_period <= w_nxt_period;
        // Outputs are decoded from the next state so they line up with the
        // state register rather than lagging it by a cycle.
        r_led    <= (w_nxt_state == ST_ON) || (w_nxt_state == ST_BLINK_HI) ||
                    (w_nxt_state == ST_FLASH_HI);
        r_busy   <= (w_nxt_state == ST_BLINK_HI) || (w_nxt_state == ST_BLINK_LO) ||
                    (w_nxt_state == ST_FLASH_HI) || (w_nxt_state == ST_FLASH_LO);
        r_done   <= w_nxt_done;
      end
    end

    assign led_out[gi] = r_led;
    assign busy[gi]    = r_busy;
    assign done[gi]    = r_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_ctrl
// Description : Directed scoreboard bench for led_pattern_ctrl with
//               TICK_DIV = 4. Stimulus pushes per-cycle expected outputs into
//               a queue; a monitor compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_ch = 2'd0;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_period = 8'd0;
  logic [3:0] cmd_count = 4'd0;
  logic [3:0] led_out;
  logic [3:0] busy;
  logic [3:0] done;

  led_pattern_ctrl #(
    .TICK_DIV(TICK_DIV),
    .NCH     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ch    (cmd_ch),
    .cmd_mode  (cmd_mode),
    .cmd_period(cmd_period),
    .cmd_count (cmd_count),
    .led_out   (led_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [3:0] led;
    logic [3:0] busy;
    logic [3:0] done;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;  // posedges since time 0
  int   cyc   = 0;  // posedges since reset release; equals the divider mod TICK_DIV

  always @(posedge clk) begin
    ncyc <= ncyc + 1;
    cyc  <= rst ? 0 : cyc + 1;
  end

  // Monitor: pops the entry scheduled for the current cycle and compares.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].at < ncyc) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", e.tag, e.at, ncyc);
    end
    if (q.size() > 0 && q[0].at == ncyc) begin
      e = q.pop_front();
      total++;
      if (led_out !== e.led || busy !== e.busy || done !== e.done || cmd_ready !== e.rdy) begin
        bad++;
        $display("FAIL %s cyc=%0d got led=%b busy=%b done=%b rdy=%b want led=%b busy=%b done=%b rdy=%b",
                 e.tag, ncyc, led_out, busy, done, cmd_ready, e.led, e.busy, e.done, e.rdy);
      end
    end
  end

  task automatic push_span(input int a, input int b, input logic [3:0] led,
                           input logic [3:0] bsy, input logic [3:0] dn,
                           input logic rdy, input string tag);
    exp_t e;
    for (int t = a; t <= b; t++) begin
      e.at   = t;
      e.led  = led;
      e.busy = bsy;
      e.done = dn;
      e.rdy  = rdy;
      e.tag  = tag;
      q.push_back(e);
    end
  endtask

  // Drives one command for the current cycle; returns one cycle later.
  task automatic send(input logic [1:0] ch, input logic [1:0] mode,
                      input logic [7:0] per, input logic [3:0] cnt);
    cmd_valid  = 1'b1;
    cmd_ch     = ch;
    cmd_mode   = mode;
    cmd_period = per;
    cmd_count  = cnt;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_mod(input int m);
    int guard;
    guard = 0;
    while ((cyc % TICK_DIV) != m && guard < 4 * TICK_DIV) begin
      @(negedge clk);
      guard++;
    end
    if ((cyc % TICK_DIV) != m) begin
      total++;
      bad++;
      $display("FAIL align: timebase phase %0d never reached", m);
    end
  endtask

  task automatic wait_until(input int t);
    while (ncyc < t) @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int n;

    // ---- Reset: held for three edges, ready rises on the first free edge
    push_span(1, 3, 4'b0000, 4'b0000, 4'b0000, 1'b0, "reset");
    push_span(4, 5, 4'b0000, 4'b0000, 4'b0000, 1'b1, "post_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drain();

    // ---- ON then OFF on channel 2
    n = ncyc;
    push_span(n + 1, n + 10, 4'b0100, 4'b0000, 4'b0000, 1'b1, "on_ch2");
    push_span(n + 11, n + 12, 4'b0000, 4'b0000, 4'b0000, 1'b1, "off_ch2");
    send(2'd2, 2'b01, 8'd0, 4'd0);
    wait_until(n + 10);
    send(2'd2, 2'b00, 8'd0, 4'd0);
    drain();

    // ---- BLINK ch0, period 2, loaded mid-tick-interval: first HI is 7 cycles
    wait_mod(0);
    n = ncyc;
    push_span(n + 1, n + 7, 4'b0001, 4'b0001, 4'b0000, 1'b1, "blink_first");
    for (int p = 1; p <= 5; p++)
      push_span(n + 8 * p, n + 8 * p + 7, (p % 2 == 1) ? 4'b0000 : 4'b0001,
                4'b0001, 4'b0000, 1'b1, "blink_toggle");
    push_span(n + 48, n + 52, 4'b0001, 4'b0001, 4'b0000, 1'b1, "blink_last");
    push_span(n + 53, n + 54, 4'b0000, 4'b0000, 4'b0000, 1'b1, "blink_off");
    send(2'd0, 2'b10, 8'd2, 4'd0);
    wait_until(n + 52);
    send(2'd0, 2'b00, 8'd0, 4'd0);
    drain();

    // ---- FLASH ch1, period 1, count 3, loaded on a tick cycle (tick dropped)
    wait_mod(TICK_DIV - 1);
    n = ncyc;
    for (int p = 0; p < 3; p++) begin
      push_span(n + 1 + 8 * p, n + 4 + 8 * p, 4'b0010, 4'b0010, 4'b0000, 1'b1, "flash_hi");
      push_span(n + 5 + 8 * p, n + 8 + 8 * p, 4'b0000, 4'b0010, 4'b0000, 1'b1, "flash_lo");
    end
    push_span(n + 25, n + 25, 4'b0000, 4'b0000, 4'b0010, 1'b1, "flash_done");
    push_span(n + 26, n + 27, 4'b0000, 4'b0000, 4'b0000, 1'b1, "flash_idle");
    send(2'd1, 2'b11, 8'd1, 4'd3);
    drain();

    // ---- FLASH ch3 with count 0: immediate done, never lit or busy
    n = ncyc;
    push_span(n + 1, n + 1, 4'b0000, 4'b0000, 4'b1000, 1'b1, "flash0_done");
    push_span(n + 2, n + 3, 4'b0000, 4'b0000, 4'b0000, 1'b1, "flash0_idle");
    send(2'd3, 2'b11, 8'd5, 4'd0);
    drain();

    // ---- FLASH ch3 count 5 aborted by ON after two pulses: no done
    wait_mod(TICK_DIV - 1);
    n = ncyc;
    push_span(n + 1, n + 4, 4'b1000, 4'b1000, 4'b0000, 1'b1, "abort_hi1");
    push_span(n + 5, n + 8, 4'b0000, 4'b1000, 4'b0000, 1'b1, "abort_lo1");
    push_span(n + 9, n + 12, 4'b1000, 4'b1000, 4'b0000, 1'b1, "abort_hi2");
    push_span(n + 13, n + 14, 4'b0000, 4'b1000, 4'b0000, 1'b1, "abort_lo2");
    push_span(n + 15, n + 30, 4'b1000, 4'b0000, 4'b0000, 1'b1, "abort_on");
    push_span(n + 31, n + 32, 4'b0000, 4'b0000, 4'b0000, 1'b1, "abort_off");
    send(2'd3, 2'b11, 8'd1, 4'd5);
    wait_until(n + 14);
    send(2'd3, 2'b01, 8'd0, 4'd0);
    wait_until(n + 30);
    send(2'd3, 2'b00, 8'd0, 4'd0);
    drain();

    // ---- Reload BLINK on a tick cycle, then reset during a FLASH burst
    wait_mod(0);
    n = ncyc;
    push_span(n + 1, n + 7, 4'b0001, 4'b0001, 4'b0000, 1'b1, "reload_hi0");
    push_span(n + 8, n + 11, 4'b0000, 4'b0001, 4'b0000, 1'b1, "reload_lo0");
    push_span(n + 12, n + 19, 4'b0001, 4'b0001, 4'b0000, 1'b1, "reload_hi1");
    push_span(n + 20, n + 23, 4'b0000, 4'b0001, 4'b0000, 1'b1, "reload_lo1");
    push_span(n + 24, n + 27, 4'b0010, 4'b0011, 4'b0000, 1'b1, "mix_a");
    push_span(n + 28, n + 31, 4'b0001, 4'b0011, 4'b0000, 1'b1, "mix_b");
    push_span(n + 32, n + 33, 4'b0011, 4'b0011, 4'b0000, 1'b1, "mix_c");
    push_span(n + 34, n + 35, 4'b0000, 4'b0000, 4'b0000, 1'b0, "mid_reset");
    push_span(n + 36, n + 41, 4'b0000, 4'b0000, 4'b0000, 1'b1, "after_reset");
    send(2'd0, 2'b10, 8'd2, 4'd0);
    wait_until(n + 11);
    send(2'd0, 2'b10, 8'd2, 4'd0);
    wait_until(n + 23);
    send(2'd1, 2'b11, 8'd1, 4'd2);
    wait_until(n + 33);
    rst = 1'b1;
    wait_until(n + 35);
    rst = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Output-side companion to the board key-input path: it drives the four user LEDs under command control.
- Upstream logic issues per-channel commands: off, on, continuous blink, or a burst of N flashes. The block generates all timing from a shared millisecond tick.
- It reports per-channel busy status and a completion pulse when a flash burst ends.

Parameters:
- TICK_DIV, 50000, clk cycles per timebase tick (50000 gives 1 ms at 50 MHz); must be >= 2
- NCH, 4, number of LED channels (fixed at 4 for this board)

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block accepts command this cycle
- cmd_ch  input  2  target channel 0..3
- cmd_mode  input  2  00 OFF, 01 ON, 10 BLINK, 11 FLASH
- cmd_period  input  8  half-period in ticks; 0 is treated as 1
- cmd_count  input  4  FLASH pulse count; 0 means no pulses
- led_out  output  4  LED drive, 1 = lit
- busy  output  4  channel is in BLINK or FLASH activity
- done  output  4  one-cycle pulse when a FLASH burst completes

Behaviour:
- Clocking and reset
  - One clock: clk. rst is synchronous, active-high, sampled on the rising edge of clk.
  - While rst = 1: led_out = 0, busy = 0, done = 0, cmd_ready = 0, tick divider = 0, every channel in OFF.
  - cmd_ready = 1 from the first cycle after rst deasserts.
  - Reset mid-operation aborts all activity immediately; no done pulse is generated.
- Handshake
  - A command is accepted when cmd_valid & cmd_ready on a rising edge. At most one command per cycle.
  - The command takes effect in registers at that edge, so led_out reflects it one cycle after acceptance.
- Timebase
  - A free-running divider counts 0..TICK_DIV-1.
  - tick = 1 for the single cycle where divider = TICK_DIV-1; the divider then wraps to 0.
  - The divider is not reset by commands.
- Per-channel state
  - Registers: state, phase counter (8b), pulses remaining (4b), period (8b).
  - States: OFF, ON, BLINK_HI, BLINK_LO, FLASH_HI, FLASH_LO.
  - led_out = 1 in ON, BLINK_HI and FLASH_HI; 0 otherwise.
  - busy = 1 in the BLINK and FLASH states.
- Command load (any state)
  - Phase counter cleared to 0; period latched as max(cmd_period, 1).
  - OFF -> state OFF.
  - ON -> state ON.
  - BLINK -> state BLINK_HI.
  - FLASH with cmd_count = 0 -> state OFF, and done pulses in the acceptance cycle's next cycle.
  - FLASH with cmd_count = K > 0 -> state FLASH_HI, pulses remaining = K.
- Timing
  - On each tick in BLINK_* or FLASH_*: if phase counter = period-1, the counter clears and a phase transition occurs; otherwise the counter increments.
  - BLINK_HI <-> BLINK_LO toggles indefinitely.
  - FLASH_HI -> FLASH_LO.
  - FLASH_LO: decrement pulses remaining. If the result is 0, go to OFF and assert done for one cycle. Otherwise go to FLASH_HI.
  - The first phase after a load lasts between period-1 and period ticks, because the tick is not aligned to the command. Every later phase lasts exactly period*TICK_DIV cycles.
- Simultaneous events
  - Command load wins over a tick on the same channel in the same cycle. The tick is ignored for that channel.
  - A new command aborts an in-progress FLASH with no done pulse.
  - Channels are fully independent; done may pulse on several channels in the same cycle.
  - A command to one channel never disturbs another channel.

Test Plan:
- TICK_DIV=4. Reset held 3 cycles then released -> led_out=0000, busy=0000, done=0000, cmd_ready=0 during reset and 1 the next cycle.
- ON to ch2, then OFF to ch2 after 10 cycles -> led_out[2] is 1 one cycle after the ON accept and 0 one cycle after the OFF accept. Other bits stay 0.
- BLINK ch0, period=2 -> after the first phase, led_out[0] toggles every 8 cycles for at least 6 toggles. busy[0]=1 throughout.
- FLASH ch1, period=1, count=3 -> exactly 3 high pulses of 4 cycles each, separated by 4-cycle lows. done[1] pulses once for 1 cycle at the end of the last low phase. busy[1] then goes to 0 and led_out[1]=0.
- FLASH ch3, count=0 -> led_out[3] stays 0, done[3] pulses 1 cycle after accept, busy[3] stays 0. In a second case, a FLASH count=5 is interrupted by ON after 2 pulses -> no done, led_out[3]=1 steady.
- Command accepted in the exact cycle tick=1 on a blinking channel, plus rst asserted mid-FLASH -> phase counter restarts from 0 with no spurious toggle. The reset clears all outputs next edge with no done pulse.
